// File: rtl/dt_discretize_seq.sv
// Token sequencer for the shared exp/softplus cell: dt -> softplus -> delta,
// then streams dA[n] = exp(sat(delta*A[n])) for every state channel.
module dt_discretize_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 12,
  parameter int D_STATE    = 16,
  parameter int IDX_W      = $clog2(D_STATE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_dt,
  input  logic                  a_we,
  input  logic [IDX_W-1:0]      a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  cell_valid,
  output logic [DATA_WIDTH-1:0] cell_x,
  output logic                  cell_mode,
  input  logic [DATA_WIDTH-1:0] cell_y,
  input  logic                  cell_valid_out,
  output logic                  delta_valid,
  output logic [DATA_WIDTH-1:0] delta_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_last,
  output logic                  busy
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic signed [PW-1:0] SAT_MAX = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(D_STATE - 1);

  typedef enum logic [2:0] {IDLE, SP_ISSUE, SP_WAIT, EX_ISSUE, EX_WAIT, OUT_HOLD} state_t;

  state_t                 state, state_nxt;
  logic [DATA_WIDTH-1:0]  dt_reg;
  logic [IDX_W-1:0]       n;
  logic                   mode_q;
  logic [DATA_WIDTH-1:0]  a_tab [D_STATE];
  logic signed [PW-1:0]   prod, prod_sh;
  logic [DATA_WIDTH-1:0]  z_sat;

  // A table: writes land at the edge, so an EX_ISSUE read sees the old value.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < D_STATE; i++) a_tab[i] <= '0;
    end else if (a_we) begin
      a_tab[a_addr] <= a_wdata;
    end

  assign prod    = $signed(delta_out) * $signed(a_tab[n]);
  assign prod_sh = prod >>> FRAC_BITS;
  assign z_sat   = (prod_sh > SAT_MAX) ? SAT_MAX[DATA_WIDTH-1:0] :
                   (prod_sh < SAT_MIN) ? SAT_MIN[DATA_WIDTH-1:0] :
                                         prod_sh[DATA_WIDTH-1:0];

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign cell_mode = (state == SP_ISSUE) ? 1'b0 : (state == EX_ISSUE) ? 1'b1 : mode_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt  = state;
    cell_valid = 1'b0;
    cell_x     = '0;
    case (state)
      IDLE:     if (in_valid) state_nxt = SP_ISSUE;
      SP_ISSUE: begin
        cell_valid = 1'b1;
        cell_x     = dt_reg;
        state_nxt  = SP_WAIT;
      end
      SP_WAIT:  if (cell_valid_out) state_nxt = EX_ISSUE;
      EX_ISSUE: begin
        cell_valid = 1'b1;
        cell_x     = z_sat;
        state_nxt  = EX_WAIT;
      end
      EX_WAIT:  if (cell_valid_out) state_nxt = OUT_HOLD;
      OUT_HOLD: if (out_ready) state_nxt = out_last ? IDLE : EX_ISSUE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dt_reg      <= '0;
      n           <= '0;
      mode_q      <= 1'b0;
      delta_valid <= 1'b0;
      delta_out   <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_idx     <= '0;
      out_last    <= 1'b0;
    end else begin
      delta_valid <= 1'b0;
      mode_q      <= cell_mode;
      case (state)
        IDLE: if (in_valid) dt_reg <= in_dt;
        SP_WAIT: if (cell_valid_out) begin
          delta_out   <= cell_y;
          delta_valid <= 1'b1;
          n           <= '0;
        end
        EX_WAIT: if (cell_valid_out) begin
          out_data  <= cell_y;
          out_idx   <= n;
          out_last  <= (n == LAST_IDX);
          out_valid <= 1'b1;
        end
        OUT_HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          if (!out_last) n <= n + 1'b1;
        end
        default: ;
      endcase
    end

endmodule

// File: tb/tb_dt_discretize_seq.sv
// Bench for dt_discretize_seq: table vectors, hand sequences for reset/backpressure/
// A-write corners, and random tokens scored against a plain-arithmetic model.
module tb_dt_discretize_seq;
  localparam int DW = 16, D = 16, IW = $clog2(D);

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_dt = '0;
  logic          a_we = 1'b0;
  logic [IW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          cell_valid, cell_mode, cell_valid_out;
  logic [DW-1:0] cell_x, cell_y;
  logic          delta_valid, out_valid, out_ready = 1'b0, out_last, busy;
  logic [DW-1:0] delta_out, out_data;
  logic [IW-1:0] out_idx;

  always #5 clk = ~clk;

  dt_discretize_seq #(.DATA_WIDTH(DW), .FRAC_BITS(12), .D_STATE(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_dt(in_dt),
    .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .cell_valid(cell_valid), .cell_x(cell_x), .cell_mode(cell_mode),
    .cell_y(cell_y), .cell_valid_out(cell_valid_out),
    .delta_valid(delta_valid), .delta_out(delta_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy));

  // Cell: identity stub by default, or a real exp/softplus in Q4.12.
  bit real_cell = 0;
  function automatic logic [DW-1:0] cell_f(input logic mode, input logic [DW-1:0] x);
    real r, v;
    int  iv;
    if (!real_cell) return x;
    r  = $itor($signed(x)) / 4096.0;
    v  = mode ? $exp(r) : $ln(1.0 + $exp(r));
    iv = $rtoi(v * 4096.0 + 0.5);
    if (iv > 32767) iv = 32767;
    return iv[DW-1:0];
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cell_valid_out <= 1'b0;
      cell_y         <= '0;
    end else begin
      cell_valid_out <= cell_valid;
      if (cell_valid) cell_y <= cell_f(cell_mode, cell_x);
    end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: delta = cell(dt); dA[n] = cell(clamp(floor(delta*A[n]/4096))).
  logic [DW-1:0] a_model [D];
  int            exp_delta;
  int            exp_da [D];

  function automatic int floor_div4096(input longint p);
    if (p >= 0) return int'(p / 4096);
    return int'(-((-p + 4095) / 4096));
  endfunction

  task automatic model_token(input logic [DW-1:0] dt);
    int            zi;
    logic [DW-1:0] zb;
    exp_delta = $signed(cell_f(1'b0, dt));
    for (int i = 0; i < D; i++) begin
      zi = floor_div4096(longint'(exp_delta) * longint'($signed(a_model[i])));
      if (zi > 32767)  zi = 32767;
      if (zi < -32768) zi = -32768;
      zb = DW'(zi);
      exp_da[i] = $signed(cell_f(1'b1, zb));
    end
  endtask

  task automatic do_reset();
    in_valid = 0; a_we = 0; out_ready = 0;
    #2 rst_n = 0;
    for (int i = 0; i < D; i++) a_model[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
  endtask

  task automatic write_a(input int addr, input logic [DW-1:0] val);
    @(negedge clk);
    a_we = 1; a_addr = IW'(addr); a_wdata = val;
    @(negedge clk);
    a_we = 0;
    a_model[addr] = val;
  endtask

  // rmode: 0 ready always, 2 stall element 3 for 7 cycles, 3 random ready + junk in_valid.
  // wr_cyc > 0 fires an A write in that cycle of the token.
  task automatic run_token(input logic [DW-1:0] dt, input bit use_model, input int rmode,
                           input int wr_cyc, input int wr_addr, input logic [DW-1:0] wr_data);
    int cyc, got, vis, hs_cyc;
    bit overlap, rdy;
    if (use_model) model_token(dt);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; in_dt = dt; out_ready = 0;
    @(posedge clk);
    #1 in_valid = 0; in_dt = DW'($urandom);
    cyc = 0; got = 0; vis = 0; hs_cyc = 0; overlap = 0;
    while (got < D && cyc < 400) begin
      @(negedge clk);
      cyc++;
      a_we = 0;
      if (cell_valid && cell_valid_out) overlap = 1;
      if (cyc == 1) chk("sp_issue", {cell_valid, cell_mode, cell_x}, {2'b10, dt});
      if (cyc == 3) begin
        chk("delta_valid", delta_valid, 1);
        chk("delta_out", $signed(delta_out), exp_delta);
      end
      if (cyc == wr_cyc) begin
        chk("wr_in_ex_issue", {cell_valid, cell_mode}, 2'b11);
        a_we = 1; a_addr = IW'(wr_addr); a_wdata = wr_data;
      end
      if (out_valid) begin
        vis++;
        chk("da_data", $signed(out_data), exp_da[got]);
        chk("da_idx", out_idx, got);
        chk("da_last", out_last, got == D-1);
        if (vis == 1) chk("da_cadence", cyc, (got == 0) ? 5 : hs_cyc + 3);
        else          chk("no_cell_req_hold", cell_valid, 0);
        rdy = (rmode == 2) ? !(got == 3 && vis <= 7) : (rmode == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
      end else begin
        rdy = (rmode == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      out_ready = rdy;
      if (out_valid && rdy) begin got++; vis = 0; hs_cyc = cyc; end
      in_valid = (rmode == 3 && got < D) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    in_valid = 0;
    if (got < D) chk("token_timeout", got, D);
    if (rmode == 0) chk("token_len", hs_cyc, 2 + 3*D);
    chk("cell_overlap", overlap, 0);
    @(negedge clk);
    a_we = 0;
    chk("in_ready_after", {in_ready, busy}, 2'b10);
    if (wr_cyc > 0) a_model[wr_addr] = wr_data;
  endtask

  typedef struct {
    logic [DW-1:0] dt, a0, a1, a2;
    int            delta, d0, d1, d2;
  } vec_t;
  vec_t vt [2];

  initial begin
    bit seen;
    vt[0] = '{16'd8192, 16'd28672, 16'hB000, 16'hFFFF, 8192, 32767, -32768, -2};
    vt[1] = '{16'd1,    16'hFFFF,  16'd1,    16'd0,    1,    -1,    0,      0};

    // Reset state and quiet idle
    do_reset();
    chk("rst_ready_busy", {in_ready, busy}, 2'b10);
    chk("rst_valids", {out_valid, cell_valid, delta_valid, out_last}, 0);
    chk("rst_regs", {delta_out, out_data, out_idx}, 0);
    seen = 0;
    repeat (20) @(negedge clk) if (cell_valid || busy) seen = 1;
    chk("idle_no_req", seen, 0);

    // Table vectors: saturation and floor rounding
    for (int v = 0; v < 2; v++) begin
      do_reset();
      write_a(0, vt[v].a0); write_a(1, vt[v].a1); write_a(2, vt[v].a2);
      exp_delta = vt[v].delta;
      for (int i = 0; i < D; i++) exp_da[i] = 0;
      exp_da[0] = vt[v].d0; exp_da[1] = vt[v].d1; exp_da[2] = vt[v].d2;
      run_token(vt[v].dt, 0, 0, 0, 0, '0);
    end

    // Backpressure on element 3
    do_reset();
    for (int i = 0; i < D; i++) write_a(i, DW'($urandom));
    run_token(16'd4096, 1, 2, 0, 0, '0);

    // Real cell, dt=0, A=0: every dA is exp(0)=4096
    do_reset();
    real_cell = 1;
    run_token(16'd0, 1, 0, 0, 0, '0);
    chk("real_da0", exp_da[0], 4096);
    real_cell = 0;

    // Reset during EX_WAIT of element 5
    do_reset();
    for (int i = 0; i < D; i++) write_a(i, DW'($urandom));
    @(negedge clk) in_valid = 1; in_dt = 16'd4096; out_ready = 1;
    @(posedge clk) #1 in_valid = 0;
    repeat (19) @(negedge clk);
    chk("pre_rst_ex_wait", {busy, out_valid, cell_valid_out, out_idx}, {3'b101, IW'(4)});
    #1 rst_n = 0;
    #1;
    chk("async_rst_outs", {out_valid, busy, cell_valid, delta_valid, out_last}, 0);
    chk("async_rst_regs", {in_ready, delta_out, out_data, out_idx}, {1'b1, {(2*DW+IW){1'b0}}});
    for (int i = 0; i < D; i++) a_model[i] = '0;
    @(negedge clk) rst_n = 1;
    seen = 0;
    repeat (5) @(negedge clk) if (out_valid || busy) seen = 1;
    chk("no_partial_after_rst", seen, 0);
    run_token(DW'($urandom), 1, 0, 0, 0, '0);

    // A write during EX_ISSUE of element 2 (cycle 9)
    do_reset();
    write_a(2, 16'd1000);
    run_token(16'd4096, 1, 0, 9, 2, 16'd2000);
    run_token(16'd4096, 1, 0, 0, 0, '0);
    chk("new_a_used", exp_da[2], 2000);

    // Random tokens, random backpressure and ignored in_valid
    do_reset();
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < D; i++) write_a(i, DW'($urandom));
      run_token(DW'($urandom), 1, 3, 0, 0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
